rx_iod_multilane_bit_align: RTL and testbench

- Parametrised successor to the single-lane RX IOD bit aligner.
- Trains NUM_LANES IOD receive lanes in turn from one shared FSM. For each lane it sweeps the tap delay, finds the longest run of taps where the IOD EARLY/LATE flags stay low, and parks the tap at the centre of that run.
- Sits between the IOD/CDR lane primitives and the lane-deskew/word-align logic.
- Reports per-lane done, error and tap value.

---
 rtl/rx_iod_multilane_bit_align.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_rx_iod_multilane_bit_align.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_iod_multilane_bit_align.sv
// Multi-lane RX IOD bit aligner: one FSM sweeps each lane's tap delay and parks it mid-eye.
// Optional macro RXALGN_SKIP_EN adds BIT_ALGN_SKIP / SKIP_TAP to bypass the eye search.
module rx_iod_multilane_bit_align #(
    parameter int NUM_LANES  = 4,
    parameter int TAP_W      = 7,
    parameter int MAX_TAP    = 127,
    parameter int SETTLE_CYC = 4,
    parameter int SAMPLE_CYC = 8,
    parameter int MIN_EYE    = 8
`ifdef RXALGN_SKIP_EN
    , parameter int SKIP_TAP = 64
`endif
) (
    input  logic                         SCLK,
    input  logic                         RESETN,
    input  logic                         PLL_LOCK,
    input  logic                         BIT_ALGN_RSTRT,
    input  logic                         BIT_ALGN_HOLD,
`ifdef RXALGN_SKIP_EN
    input  logic                         BIT_ALGN_SKIP,
`endif
    input  logic [NUM_LANES-1:0]         IOD_EARLY,
    input  logic [NUM_LANES-1:0]         IOD_LATE,
    input  logic [NUM_LANES-1:0]         IOD_OOR,
    output logic [NUM_LANES-1:0]         BIT_ALGN_CLR_FLGS,
    output logic [NUM_LANES-1:0]         BIT_ALGN_LOAD,
    output logic [NUM_LANES-1:0]         BIT_ALGN_MOVE,
    output logic [NUM_LANES-1:0]         BIT_ALGN_DIR,
    output logic                         BIT_ALGN_START,
    output logic                         BIT_ALGN_DONE,
    output logic                         BIT_ALGN_ERR,
    output logic [NUM_LANES-1:0]         LANE_DONE,
    output logic [NUM_LANES-1:0]         LANE_ERR,
    output logic [NUM_LANES*TAP_W-1:0]   LANE_TAPDLY
);
    localparam int LW  = TAP_W + 1;
    localparam int LIW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW  = $clog2(SETTLE_CYC + SAMPLE_CYC + 1) + 1;

    typedef enum logic [3:0] {
        ST_IDLE, ST_LOAD, ST_CLR, ST_SETTLE, ST_SAMPLE,
        ST_EVAL, ST_STEP, ST_CENTER, ST_NEXT, ST_FIN
`ifdef RXALGN_SKIP_EN
        , ST_SKIP
`endif
    } state_t;

    state_t                       state_q, state_d;
    logic [LIW-1:0]               lane_idx_q, lane_idx_d;
    logic [TAP_W-1:0]             tap_q, tap_d, eye_start_q, eye_start_d, best_start_q, best_start_d;
    logic [LW-1:0]                eye_len_q, eye_len_d, best_len_q, best_len_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         bad_q, bad_d, lock_meta_q, lock_meta_d, lock_sync_q, lock_sync_d;
    logic                         rstrt_q, rstrt_d, start_q, start_d, done_q, done_d, err_q, err_d;
    logic [NUM_LANES-1:0]         lane_done_q, lane_done_d, lane_err_q, lane_err_d;
    logic [NUM_LANES-1:0]         clr_q, clr_d, load_q, load_d, move_q, move_d, dir_q, dir_d;
    logic [NUM_LANES*TAP_W-1:0]   tapdly_q, tapdly_d;
`ifdef RXALGN_SKIP_EN
    logic                         skip_q, skip_d;
`endif

    logic [NUM_LANES-1:0]         lane_oh_s;
    logic                         flag_s, oor_s, rstrt_rise_s, scan_end_s;
    logic [TAP_W-1:0]             e_start_s, cand_start_s;
    logic [LW-1:0]                e_len_s, cand_len_s, target_s;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d      = state_q;
        lane_idx_d   = lane_idx_q;
        tap_d        = tap_q;
        eye_start_d  = eye_start_q;
        eye_len_d    = eye_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        cnt_d        = cnt_q;
        bad_d        = bad_q;
        start_d      = start_q;
        done_d       = done_q;
        lane_done_d  = lane_done_q;
        lane_err_d   = lane_err_q;
        tapdly_d     = tapdly_q;
        clr_d        = '0;
        load_d       = '0;
        move_d       = '0;
        dir_d        = '0;
`ifdef RXALGN_SKIP_EN
        skip_d       = skip_q;
`endif
        lock_meta_d  = PLL_LOCK;
        lock_sync_d  = lock_meta_q;
        rstrt_d      = BIT_ALGN_RSTRT;
        rstrt_rise_s = BIT_ALGN_RSTRT & ~rstrt_q;

        lane_oh_s             = '0;
        lane_oh_s[lane_idx_q] = 1'b1;
        flag_s     = IOD_EARLY[lane_idx_q] | IOD_LATE[lane_idx_q];
        oor_s      = IOD_OOR[lane_idx_q];
        scan_end_s = ({1'b0, tap_q} == LW'(MAX_TAP)) || oor_s;
        target_s   = {1'b0, best_start_q} + (best_len_q >> 1);
        e_start_s  = (eye_len_q == '0) ? tap_q : eye_start_q;
        e_len_s    = eye_len_q + LW'(1);
        // A bad tap closes the previous run; at scan end a still-open run closes including this tap
        if (bad_q) begin
            cand_start_s = eye_start_q;
            cand_len_s   = eye_len_q;
        end else begin
            cand_start_s = e_start_s;
            cand_len_s   = e_len_s;
        end

        if (!lock_sync_q || rstrt_rise_s) begin
            state_d     = ST_IDLE;
            lane_idx_d  = '0;
            start_d     = 1'b0;
            done_d      = 1'b0;
            lane_done_d = '0;
            lane_err_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!BIT_ALGN_HOLD && !done_q) begin
                        state_d = ST_LOAD;
                        start_d = 1'b1;
`ifdef RXALGN_SKIP_EN
                        skip_d  = BIT_ALGN_SKIP;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    load_d       = lane_oh_s;
                    tap_d        = '0;
                    eye_start_d  = '0;
                    eye_len_d    = '0;
                    best_start_d = '0;
                    best_len_d   = '0;
`ifdef RXALGN_SKIP_EN
                    state_d      = skip_q ? ST_SKIP : ST_CLR;
`else
                    state_d      = ST_CLR;
`endif
                end
                ST_CLR: begin
                    if (BIT_ALGN_HOLD) begin
                        state_d = ST_CLR;
                    end else begin
                        clr_d   = lane_oh_s;
                        cnt_d   = '0;
                        bad_d   = 1'b0;
                        state_d = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_SAMPLE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                ST_SAMPLE: begin
                    bad_d = bad_q | flag_s;
                    if (cnt_q == CW'(SAMPLE_CYC - 1)) begin
                        state_d = ST_EVAL;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                ST_EVAL: begin
                    if (bad_q) begin
                        eye_len_d   = '0;
                    end else begin
                        eye_start_d = e_start_s;
                        eye_len_d   = e_len_s;
                    end
                    if ((bad_q || scan_end_s) && (cand_len_s > best_len_q)) begin
                        best_start_d = cand_start_s;
                        best_len_d   = cand_len_s;
                    end else begin
                        best_len_d   = best_len_q;
                    end
                    state_d = scan_end_s ? ST_CENTER : ST_STEP;
                end
                ST_STEP: begin
                    move_d  = lane_oh_s;
                    dir_d   = lane_oh_s;
                    tap_d   = tap_q + TAP_W'(1);
                    state_d = ST_CLR;
                end
                ST_CENTER: begin
                    if (best_len_q < LW'(MIN_EYE)) begin
                        lane_err_d[lane_idx_q]                      = 1'b1;
                        lane_done_d[lane_idx_q]                     = 1'b1;
                        load_d                                      = lane_oh_s;
                        tap_d                                       = '0;
                        tapdly_d[int'(lane_idx_q)*TAP_W +: TAP_W]   = '0;
                        state_d                                     = ST_NEXT;
                    end else if ({1'b0, tap_q} != target_s) begin
                        move_d = lane_oh_s;
                        tap_d  = tap_q - TAP_W'(1);
                    end else begin
                        lane_done_d[lane_idx_q]                     = 1'b1;
                        tapdly_d[int'(lane_idx_q)*TAP_W +: TAP_W]   = target_s[TAP_W-1:0];
                        state_d                                     = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (lane_idx_q == LIW'(NUM_LANES - 1)) begin
                        done_d  = 1'b1;
                        start_d = 1'b0;
                        state_d = ST_FIN;
                    end else begin
                        lane_idx_d = lane_idx_q + LIW'(1);
                        state_d    = ST_LOAD;
                    end
                end
                ST_FIN: begin
                    state_d = ST_FIN;
                end
`ifdef RXALGN_SKIP_EN
                ST_SKIP: begin
                    if (tap_q != TAP_W'(SKIP_TAP)) begin
                        move_d = lane_oh_s;
                        dir_d  = lane_oh_s;
                        tap_d  = tap_q + TAP_W'(1);
                    end else begin
                        lane_err_d[lane_idx_q]                      = 1'b0;
                        lane_done_d[lane_idx_q]                     = 1'b1;
                        tapdly_d[int'(lane_idx_q)*TAP_W +: TAP_W]   = TAP_W'(SKIP_TAP);
                        state_d                                     = ST_NEXT;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        err_d = |lane_err_d;
    end

    // State, datapath and output registers
    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= ST_IDLE;
            lane_idx_q   <= '0;
            tap_q        <= '0;
            eye_start_q  <= '0;
            eye_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            cnt_q        <= '0;
            bad_q        <= 1'b0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            rstrt_q      <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            lane_done_q  <= '0;
            lane_err_q   <= '0;
            tapdly_q     <= '0;
            clr_q        <= '0;
            load_q       <= '0;
            move_q       <= '0;
            dir_q        <= '0;
`ifdef RXALGN_SKIP_EN
            skip_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lane_idx_q   <= lane_idx_d;
            tap_q        <= tap_d;
            eye_start_q  <= eye_start_d;
            eye_len_q    <= eye_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            cnt_q        <= cnt_d;
            bad_q        <= bad_d;
            lock_meta_q  <= lock_meta_d;
            lock_sync_q  <= lock_sync_d;
            rstrt_q      <= rstrt_d;
            start_q      <= start_d;
            done_q       <= done_d;
            err_q        <= err_d;
            lane_done_q  <= lane_done_d;
            lane_err_q   <= lane_err_d;
            tapdly_q     <= tapdly_d;
            clr_q        <= clr_d;
            load_q       <= load_d;
            move_q       <= move_d;
            dir_q        <= dir_d;
`ifdef RXALGN_SKIP_EN
            skip_q       <= skip_d;
`endif
        end
    end

    assign BIT_ALGN_CLR_FLGS = clr_q;
    assign BIT_ALGN_LOAD     = load_q;
    assign BIT_ALGN_MOVE     = move_q;
    assign BIT_ALGN_DIR      = dir_q;
    assign BIT_ALGN_START    = start_q;
    assign BIT_ALGN_DONE     = done_q;
    assign BIT_ALGN_ERR      = err_q;
    assign LANE_DONE         = lane_done_q;
    assign LANE_ERR          = lane_err_q;
    assign LANE_TAPDLY       = tapdly_q;
endmodule

// File: tb/tb_rx_iod_multilane_bit_align.sv
// Self-checking bench: models each lane's IOD tap and eye, and predicts final taps from eye patterns.
module tb_rx_iod_multilane_bit_align;
    localparam int NL   = 4;
    localparam int TW   = 7;
    localparam int MAXT = 127;
    localparam int MINE = 8;

    logic SCLK = 1'b0;
    logic RESETN = 1'b0;
    logic PLL_LOCK = 1'b0;
    logic RSTRT = 1'b0;
    logic HOLD = 1'b0;
`ifdef RXALGN_SKIP_EN
    logic SKIP = 1'b0;
`endif
    logic [NL-1:0]    early, late, oor;
    logic [NL-1:0]    clr_flgs, load, move, dir, lane_done, lane_err;
    logic             start, done, err;
    logic [NL*TW-1:0] tapdly;

    int checks = 0;
    int errors = 0;

    logic [127:0] good_m [NL];
    int           oor_tap [NL];
    int           tap_m [NL];
    int           up_cnt [NL];
    int           viol = 0;
    int           pulse_cnt = 0;
    logic [NL-1:0] rnd = '0;

    rx_iod_multilane_bit_align dut (
        .SCLK(SCLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK),
        .BIT_ALGN_RSTRT(RSTRT), .BIT_ALGN_HOLD(HOLD),
`ifdef RXALGN_SKIP_EN
        .BIT_ALGN_SKIP(SKIP),
`endif
        .IOD_EARLY(early), .IOD_LATE(late), .IOD_OOR(oor),
        .BIT_ALGN_CLR_FLGS(clr_flgs), .BIT_ALGN_LOAD(load), .BIT_ALGN_MOVE(move),
        .BIT_ALGN_DIR(dir), .BIT_ALGN_START(start), .BIT_ALGN_DONE(done),
        .BIT_ALGN_ERR(err), .LANE_DONE(lane_done), .LANE_ERR(lane_err),
        .LANE_TAPDLY(tapdly)
    );

    always #5 SCLK = ~SCLK;

    // IOD lane model: tap follows LOAD/MOVE pulses; protocol violations are tallied
    always @(posedge SCLK) begin
        rnd <= NL'($urandom);
        if (!RESETN) begin
            for (int l = 0; l < NL; l++) begin
                tap_m[l]  <= 0;
                up_cnt[l] <= 0;
            end
        end else begin
            if (|(clr_flgs | load | move)) pulse_cnt <= pulse_cnt + 1;
            if ($countones(clr_flgs | load | move) > 1 || (dir & ~move) != '0) viol <= viol + 1;
            for (int l = 0; l < NL; l++) begin
                if (load[l]) begin
                    tap_m[l] <= 0;
                end else if (move[l] && dir[l]) begin
                    if (tap_m[l] >= MAXT || tap_m[l] >= oor_tap[l]) viol <= viol + 1;
                    tap_m[l]  <= tap_m[l] + 1;
                    up_cnt[l] <= up_cnt[l] + 1;
                end else if (move[l]) begin
                    if (tap_m[l] == 0) viol <= viol + 1;
                    tap_m[l] <= tap_m[l] - 1;
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NL; l++) begin
            early[l] = ~good_m[l][tap_m[l][6:0]] & rnd[l];
            late[l]  = ~good_m[l][tap_m[l][6:0]] & ~rnd[l];
            oor[l]   = (tap_m[l] >= oor_tap[l]);
        end
    end

    // Longest clean run over the scanned range; earliest wins ties
    function automatic void model(input logic [127:0] g, input int oor_t, output int tap, output bit e);
        int last, bs, bl, rs, rl;
        last = (oor_t < MAXT) ? oor_t : MAXT;
        bs = 0; bl = 0; rs = 0; rl = 0;
        for (int t = 0; t <= last; t++) begin
            if (g[t]) begin
                if (rl == 0) rs = t;
                rl++;
                if (rl > bl) begin bl = rl; bs = rs; end
            end else begin
                rl = 0;
            end
        end
        e   = (bl < MINE);
        tap = e ? 0 : bs + bl / 2;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge SCLK);
        #1;
    endtask

    task automatic clear_patterns();
        for (int l = 0; l < NL; l++) begin
            good_m[l]  = '0;
            oor_tap[l] = 128;
        end
    endtask

    task automatic set_eye(input int l, input int lo, input int hi);
        for (int t = lo; t <= hi && t <= 127; t++) good_m[l][t] = 1'b1;
    endtask

    task automatic rand_patterns();
        int n, lo, len;
        clear_patterns();
        for (int l = 0; l < NL; l++) begin
            n = $urandom_range(3, 1);
            for (int k = 0; k < n; k++) begin
                lo  = $urandom_range(120, 0);
                len = $urandom_range(40, 1);
                set_eye(l, lo, lo + len - 1);
            end
            if ($urandom_range(3, 0) == 0) oor_tap[l] = $urandom_range(127, 50);
        end
    endtask

    task automatic restart();
        tick(1);
        RSTRT = 1'b1;
        tick(2);
        RSTRT = 1'b0;
        tick(3);
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 12000 && !done; i++) tick(1);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: DONE=%b required 1", nm, done);
        end
    endtask

    task automatic check_run(input string nm, input int viol0);
        int  et;
        bit  ee;
        logic any_err;
        any_err = 1'b0;
        for (int l = 0; l < NL; l++) begin
            model(good_m[l], oor_tap[l], et, ee);
            any_err |= ee;
            checks++;
            if ({lane_err[l], tapdly[l*TW +: TW]} !== {ee, TW'(et)}) begin
                errors++;
                $display("FAIL %s lane%0d: err=%b tap=%0d required err=%b tap=%0d",
                         nm, l, lane_err[l], tapdly[l*TW +: TW], ee, et);
            end
        end
        checks++;
        if ({done, start, err, lane_done} !== {1'b1, 1'b0, any_err, {NL{1'b1}}}) begin
            errors++;
            $display("FAIL %s status: done=%b start=%b err=%b lane_done=%b required 1 0 %b %b",
                     nm, done, start, err, lane_done, any_err, {NL{1'b1}});
        end
        checks++;
        if (viol !== viol0) begin
            errors++;
            $display("FAIL %s pulse_protocol: violations=%0d required 0", nm, viol - viol0);
        end
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        tick(5);
        checks++;
        if ({clr_flgs, load, move, dir, start, done, err, lane_done, lane_err, tapdly} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: start=%b done=%b lane_done=%b tapdly=%h required all 0",
                     start, done, lane_done, tapdly);
        end
        RESETN = 1'b1;
        tick(10);
        checks++;
        if ({start, load} !== '0) begin
            errors++;
            $display("FAIL reset_no_lock: start=%b load=%b required 0", start, load);
        end
    endtask

    task automatic test_clean_eye();
        int v0;
        clear_patterns();
        for (int l = 0; l < NL; l++) set_eye(l, 40, 79);
        v0 = viol;
        PLL_LOCK = 1'b1;
        tick(6);
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL clean_start: START=%b required 1", start);
        end
        wait_done("clean");
        check_run("clean", v0);
    endtask

    task automatic test_narrow_eye();
        int v0;
        rand_patterns();
        good_m[2]  = '0;
        oor_tap[2] = 128;
        set_eye(2, 10, 14);
        v0 = viol;
        restart();
        wait_done("narrow");
        check_run("narrow", v0);
    endtask

    task automatic test_multi_eye();
        int v0;
        clear_patterns();
        set_eye(0, 5, 20);
        set_eye(0, 70, 100);
        set_eye(1, 60, 127);
        oor_tap[1] = 90;
        set_eye(2, 10, 19);
        set_eye(2, 50, 59);
        set_eye(3, 110, 127);
        v0 = viol;
        restart();
        wait_done("multi_eye");
        check_run("multi_eye", v0);
    endtask

    task automatic test_lock_loss();
        int v0, k, et;
        bit ee;
        rand_patterns();
        restart();
        for (int i = 0; i < 5000 && !load[1]; i++) tick(1);
        checks++;
        if (load[1] !== 1'b1) begin
            errors++;
            $display("FAIL lock_wait_lane1: LOAD[1]=%b required 1", load[1]);
        end
        tick($urandom_range(500, 20));
        PLL_LOCK = 1'b0;
        k = 0;
        for (int i = 0; i < 3 && start; i++) begin tick(1); k++; end
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL lock_start_drop: START=%b after %0d cycles required 0", start, k);
        end
        tick(20);
        model(good_m[0], oor_tap[0], et, ee);
        checks++;
        if ({start, done, err, lane_done, lane_err, tapdly[0 +: TW]} !== {3'b000, {2*NL{1'b0}}, TW'(et)}) begin
            errors++;
            $display("FAIL lock_cleared: start=%b done=%b lane_done=%b lane_err=%b tap0=%0d required 0 0 0 0 %0d",
                     start, done, lane_done, lane_err, tapdly[0 +: TW], et);
        end
        v0 = viol;
        PLL_LOCK = 1'b1;
        for (int i = 0; i < 20 && !load[0]; i++) tick(1);
        checks++;
        if (load[0] !== 1'b1) begin
            errors++;
            $display("FAIL relock_load0: LOAD[0]=%b required 1", load[0]);
        end
        wait_done("relock");
        check_run("relock", v0);
    endtask

    task automatic test_hold();
        int v0, p0, p1;
        rand_patterns();
        v0 = viol;
        restart();
        tick($urandom_range(900, 300));
        HOLD = 1'b1;
        tick(20);
        p0 = pulse_cnt;
        tick(30);
        p1 = pulse_cnt;
        checks++;
        if ({p1 - p0, start} !== {32'sd0, 1'b1}) begin
            errors++;
            $display("FAIL hold_stall: pulses=%0d start=%b required 0 1", p1 - p0, start);
        end
        HOLD = 1'b0;
        wait_done("hold");
        check_run("hold", v0);
    endtask

    task automatic test_back_to_back();
        int v0;
        rand_patterns();
        v0 = viol;
        restart();
        wait_done("random");
        check_run("random", v0);
    endtask

`ifdef RXALGN_SKIP_EN
    task automatic test_skip();
        int u0 [NL];
        for (int l = 0; l < NL; l++) u0[l] = up_cnt[l];
        SKIP = 1'b1;
        restart();
        wait_done("skip");
        for (int l = 0; l < NL; l++) begin
            checks++;
            if ({up_cnt[l] - u0[l], lane_err[l], tapdly[l*TW +: TW]} !== {32'sd64, 1'b0, TW'(64)}) begin
                errors++;
                $display("FAIL skip lane%0d: moves=%0d err=%b tap=%0d required 64 0 64",
                         l, up_cnt[l] - u0[l], lane_err[l], tapdly[l*TW +: TW]);
            end
        end
        SKIP = 1'b0;
    endtask
`endif

    initial begin
        clear_patterns();
        test_reset();
        test_clean_eye();
        test_narrow_eye();
        test_multi_eye();
        test_lock_loss();
        test_hold();
        test_back_to_back();
`ifdef RXALGN_SKIP_EN
        test_skip();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
